// File: rtl/ysyx_22040383_mem_arbiter.sv
// Shares the single pmem port between instruction fetch (IF) and the
// load/store unit (LS). One transaction is in flight at a time: the winner is
// accepted in IDLE, the request is presented in REQ until the memory takes it,
// and the response is routed back to its owner at the end of WAIT.
// LS has fixed priority, but after STARVE_MAX consecutive LS grants taken
// while IF was waiting, IF is forced to win so fetch always makes progress.
module ysyx_22040383_mem_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    input  logic              ls_req_valid,
    input  logic              ls_req_we,
    input  logic [ADDR_W-1:0] ls_req_addr,
    input  logic [DATA_W-1:0] ls_req_wdata,
    input  logic [7:0]        ls_req_wmask,
    output logic              ls_req_ready,
    output logic              ls_rsp_valid,
    output logic [DATA_W-1:0] ls_rsp_data,
    output logic              mem_req_valid,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [7:0]        mem_req_wmask,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              busy
);

    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    // Saturating increment of the starvation counter.
    function automatic logic [3:0] starve_inc(input logic [3:0] cnt);
        logic [3:0] nxt;
        if (cnt < STARVE_LIMIT) begin
            nxt = cnt + 4'd1;
        end else begin
            nxt = STARVE_LIMIT;
        end
        return nxt;
    endfunction

    state_e            state_r;
    logic              owner_ls_r;
    logic [3:0]        starve_cnt_r;
    logic              busy_r;
    logic              mem_req_valid_r;
    logic              mem_req_we_r;
    logic [ADDR_W-1:0] mem_req_addr_r;
    logic [DATA_W-1:0] mem_req_wdata_r;
    logic [7:0]        mem_req_wmask_r;
    logic              if_rsp_valid_r;
    logic [DATA_W-1:0] if_rsp_data_r;
    logic              ls_rsp_valid_r;
    logic [DATA_W-1:0] ls_rsp_data_r;

    logic              starved_s;
    logic              ls_win_s;
    logic              if_win_s;

    // Arbitration: only in IDLE, LS first unless IF has been starved long enough.
    always_comb begin
        starved_s = 1'b0;
        ls_win_s  = 1'b0;
        if_win_s  = 1'b0;
        if (state_r == ST_IDLE) begin
            starved_s = (starve_cnt_r == STARVE_LIMIT) && if_req_valid;
            if (ls_req_valid && !starved_s) begin
                ls_win_s = 1'b1;
            end else if (if_req_valid) begin
                if_win_s = 1'b1;
            end else begin
                ls_win_s = 1'b0;
                if_win_s = 1'b0;
            end
        end else begin
            starved_s = 1'b0;
        end
    end

    // Transaction FSM with all memory-side and response outputs registered.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_r         <= ST_IDLE;
            owner_ls_r      <= 1'b0;
            starve_cnt_r    <= 4'd0;
            busy_r          <= 1'b0;
            mem_req_valid_r <= 1'b0;
            mem_req_we_r    <= 1'b0;
            mem_req_addr_r  <= {ADDR_W{1'b0}};
            mem_req_wdata_r <= {DATA_W{1'b0}};
            mem_req_wmask_r <= 8'h00;
            if_rsp_valid_r  <= 1'b0;
            if_rsp_data_r   <= {DATA_W{1'b0}};
            ls_rsp_valid_r  <= 1'b0;
            ls_rsp_data_r   <= {DATA_W{1'b0}};
        end else begin
            // Responses are single-cycle pulses; data is zero outside the pulse.
            if_rsp_valid_r <= 1'b0;
            if_rsp_data_r  <= {DATA_W{1'b0}};
            ls_rsp_valid_r <= 1'b0;
            ls_rsp_data_r  <= {DATA_W{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (ls_win_s) begin
                        state_r         <= ST_REQ;
                        owner_ls_r      <= 1'b1;
                        busy_r          <= 1'b1;
                        mem_req_valid_r <= 1'b1;
                        mem_req_we_r    <= ls_req_we;
                        mem_req_addr_r  <= ls_req_addr;
                        mem_req_wdata_r <= ls_req_wdata;
                        mem_req_wmask_r <= ls_req_wmask;
                        if (if_req_valid) begin
                            starve_cnt_r <= starve_inc(starve_cnt_r);
                        end else begin
                            starve_cnt_r <= starve_cnt_r;
                        end
                    end else if (if_win_s) begin
                        state_r         <= ST_REQ;
                        owner_ls_r      <= 1'b0;
                        busy_r          <= 1'b1;
                        mem_req_valid_r <= 1'b1;
                        mem_req_we_r    <= 1'b0;
                        mem_req_addr_r  <= if_req_addr;
                        mem_req_wdata_r <= {DATA_W{1'b0}};
                        mem_req_wmask_r <= 8'h00;
                        starve_cnt_r    <= 4'd0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_r <= 1'b0;
                        state_r         <= ST_WAIT;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (mem_rsp_valid) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        if (owner_ls_r) begin
                            ls_rsp_valid_r <= 1'b1;
                            ls_rsp_data_r  <= mem_req_we_r ? {DATA_W{1'b0}} : mem_rsp_data;
                        end else begin
                            if_rsp_valid_r <= 1'b1;
                            if_rsp_data_r  <= mem_rsp_data;
                        end
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    state_r         <= ST_IDLE;
                    busy_r          <= 1'b0;
                    mem_req_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign if_req_ready  = if_win_s;
    assign ls_req_ready  = ls_win_s;
    assign if_rsp_valid  = if_rsp_valid_r;
    assign if_rsp_data   = if_rsp_data_r;
    assign ls_rsp_valid  = ls_rsp_valid_r;
    assign ls_rsp_data   = ls_rsp_data_r;
    assign mem_req_valid = mem_req_valid_r;
    assign mem_req_we    = mem_req_we_r;
    assign mem_req_addr  = mem_req_addr_r;
    assign mem_req_wdata = mem_req_wdata_r;
    assign mem_req_wmask = mem_req_wmask_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_ysyx_22040383_mem_arbiter.sv
// Self-checking bench for the IF/LS memory arbiter: table-driven arbitration
// and transaction vectors, hand-written multi-cycle sequences, and random
// traffic checked cycle by cycle against a transaction-level reference model.
module tb_ysyx_22040383_mem_arbiter;

    localparam int SM = 4;

    logic        sys_clk;
    logic        sys_rst;
    logic        if_req_valid;
    logic [63:0] if_req_addr;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [63:0] if_rsp_data;
    logic        ls_req_valid;
    logic        ls_req_we;
    logic [63:0] ls_req_addr;
    logic [63:0] ls_req_wdata;
    logic [7:0]  ls_req_wmask;
    logic        ls_req_ready;
    logic        ls_rsp_valid;
    logic [63:0] ls_rsp_data;
    logic        mem_req_valid;
    logic        mem_req_we;
    logic [63:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_data;
    logic        busy;

    ysyx_22040383_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_MAX(SM)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .ls_req_valid(ls_req_valid), .ls_req_we(ls_req_we), .ls_req_addr(ls_req_addr),
        .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask), .ls_req_ready(ls_req_ready),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .busy(busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: one outstanding transaction record plus a starvation count.
    bit          m_have, m_sent, m_ls, m_we;
    logic [63:0] m_addr, m_wdata;
    logic [7:0]  m_wmask;
    int          m_starve;
    bit          m_if_rsp, m_ls_rsp;
    logic [63:0] m_if_data, m_ls_data;

    // DUT values seen at the last check point, used by directed sequences.
    bit          s_if_ready, s_ls_ready, s_mem_valid, s_mem_we;
    logic [63:0] s_mem_addr, s_mem_wdata;
    logic [7:0]  s_mem_wmask;

    function automatic void model_clear();
        m_have = 0; m_sent = 0; m_starve = 0; m_if_rsp = 0; m_ls_rsp = 0;
    endfunction

    function automatic void model_grant(output bit g_if, output bit g_ls);
        g_if = 0; g_ls = 0;
        if (!m_have) begin
            if (ls_req_valid && !(m_starve == SM && if_req_valid)) g_ls = 1;
            else if (if_req_valid) g_if = 1;
        end
    endfunction

    function automatic void model_update();
        bit g_if, g_ls;
        model_grant(g_if, g_ls);
        m_if_rsp = 0; m_ls_rsp = 0;
        if (m_have) begin
            if (!m_sent) begin
                if (mem_req_ready) m_sent = 1;
            end else if (mem_rsp_valid) begin
                m_have = 0;
                if (m_ls) begin m_ls_rsp = 1; m_ls_data = m_we ? 64'h0 : mem_rsp_data; end
                else begin m_if_rsp = 1; m_if_data = mem_rsp_data; end
            end
        end else if (g_ls) begin
            m_have = 1; m_sent = 0; m_ls = 1; m_we = ls_req_we;
            m_addr = ls_req_addr; m_wdata = ls_req_wdata; m_wmask = ls_req_wmask;
            if (if_req_valid && m_starve < SM) m_starve = m_starve + 1;
        end else if (g_if) begin
            m_have = 1; m_sent = 0; m_ls = 0; m_we = 0;
            m_addr = if_req_addr; m_wdata = 64'h0; m_wmask = 8'h00;
            m_starve = 0;
        end
    endfunction

    task automatic check_outputs();
        bit g_if, g_ls;
        model_grant(g_if, g_ls);
        chk("if_req_ready", if_req_ready, g_if);
        chk("ls_req_ready", ls_req_ready, g_ls);
        chk("mem_req_valid", mem_req_valid, m_have && !m_sent);
        chk("busy", busy, m_have);
        chk("if_rsp_valid", if_rsp_valid, m_if_rsp);
        chk("ls_rsp_valid", ls_rsp_valid, m_ls_rsp);
        if (m_if_rsp) chk("if_rsp_data", if_rsp_data, m_if_data);
        if (m_ls_rsp) chk("ls_rsp_data", ls_rsp_data, m_ls_data);
        if (m_have && !m_sent) begin
            chk("mem_req_addr", mem_req_addr, m_addr);
            chk("mem_req_we", mem_req_we, m_we);
            chk("mem_req_wmask", mem_req_wmask, m_wmask);
            if (m_ls) chk("mem_req_wdata", mem_req_wdata, m_wdata);
        end
        s_if_ready = if_req_ready; s_ls_ready = ls_req_ready;
        s_mem_valid = mem_req_valid; s_mem_we = mem_req_we; s_mem_addr = mem_req_addr;
        s_mem_wdata = mem_req_wdata; s_mem_wmask = mem_req_wmask;
    endtask

    // One clock: called 1 time unit after a rising edge with inputs already set.
    task automatic cycle();
        #1;
        check_outputs();
        @(posedge sys_clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        if_req_valid = 0; if_req_addr = 64'h0;
        ls_req_valid = 0; ls_req_we = 0; ls_req_addr = 64'h0; ls_req_wdata = 64'h0; ls_req_wmask = 8'h00;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 64'h0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_ready"}, if_req_ready, 0);
        chk({tag, "_ls_ready"}, ls_req_ready, 0);
        chk({tag, "_if_rsp_valid"}, if_rsp_valid, 0);
        chk({tag, "_if_rsp_data"}, if_rsp_data, 0);
        chk({tag, "_ls_rsp_valid"}, ls_rsp_valid, 0);
        chk({tag, "_ls_rsp_data"}, ls_rsp_data, 0);
        chk({tag, "_mem_valid"}, mem_req_valid, 0);
        chk({tag, "_mem_we"}, mem_req_we, 0);
        chk({tag, "_mem_addr"}, mem_req_addr, 0);
        chk({tag, "_mem_wdata"}, mem_req_wdata, 0);
        chk({tag, "_mem_wmask"}, mem_req_wmask, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic apply_reset();
        idle_inputs();
        sys_rst = 0;
        model_clear();
        repeat (2) @(posedge sys_clk);
        #1;
        chk_all_zero("reset");
        sys_rst = 1;
    endtask

    typedef struct {
        bit if_v; bit ls_v; bit exp_if_rdy; bit exp_ls_rdy;
    } arb_vec_t;

    typedef struct {
        bit          ls;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] rsp;
        int          req_stall;
        int          rsp_stall;
        logic [63:0] exp_data;
    } txn_vec_t;

    task automatic run_txn(input txn_vec_t t);
        logic       exp_we;
        logic [7:0] exp_mask;
        exp_we   = t.ls ? t.we : 1'b0;
        exp_mask = t.ls ? t.wmask : 8'h00;
        idle_inputs();
        if (t.ls) begin
            ls_req_valid = 1; ls_req_we = t.we; ls_req_addr = t.addr;
            ls_req_wdata = t.wdata; ls_req_wmask = t.wmask;
        end else begin
            if_req_valid = 1; if_req_addr = t.addr;
        end
        cycle();
        chk("txn_accept_ready", t.ls ? s_ls_ready : s_if_ready, 1);
        if_req_valid = 0; ls_req_valid = 0;
        for (int i = 0; i <= t.req_stall; i++) begin
            mem_req_ready = (i == t.req_stall);
            cycle();
            chk("txn_req_valid", s_mem_valid, 1);
            chk("txn_req_addr", s_mem_addr, t.addr);
            chk("txn_req_we", s_mem_we, exp_we);
            chk("txn_req_wmask", s_mem_wmask, exp_mask);
            if (t.ls) chk("txn_req_wdata", s_mem_wdata, t.wdata);
        end
        mem_req_ready = 0;
        for (int i = 0; i < t.rsp_stall; i++) cycle();
        mem_rsp_valid = 1; mem_rsp_data = t.rsp;
        cycle();
        mem_rsp_valid = 0;
        chk("txn_owner_rsp_valid", t.ls ? ls_rsp_valid : if_rsp_valid, 1);
        chk("txn_other_rsp_valid", t.ls ? if_rsp_valid : ls_rsp_valid, 0);
        chk("txn_rsp_data", t.ls ? ls_rsp_data : if_rsp_data, t.exp_data);
        chk("txn_busy_at_rsp", busy, 0);
        cycle();
    endtask

    arb_vec_t av[4];
    txn_vec_t tv[5];
    bit       grant_if_q[$];
    int       grant_cyc_q[$];

    initial begin
        av[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        av[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
        av[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
        av[3] = '{1'b1, 1'b1, 1'b0, 1'b1};

        tv[0] = '{1'b0, 1'b0, 64'h0000_0000_8000_0000, 64'h0, 8'h00,
                  64'h0000_0013_0000_0297, 0, 0, 64'h0000_0013_0000_0297};
        tv[1] = '{1'b1, 1'b1, 64'h0000_0000_8000_1004, 64'h0000_0000_DEAD_BEEF, 8'hF0,
                  64'h1234_5678_9ABC_DEF0, 0, 0, 64'h0};
        tv[2] = '{1'b1, 1'b0, 64'h0000_0000_8000_2008, 64'h5555_AAAA_5555_AAAA, 8'hFF,
                  64'hCAFE_F00D_0BAD_BEEF, 0, 2, 64'hCAFE_F00D_0BAD_BEEF};
        tv[3] = '{1'b0, 1'b0, 64'h0000_0000_8000_0004, 64'h0, 8'h00,
                  64'h0000_0093_0000_0113, 5, 0, 64'h0000_0093_0000_0113};
        tv[4] = '{1'b1, 1'b1, 64'h0000_0000_8000_3000, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01,
                  64'h0BAD_0BAD_0BAD_0BAD, 1, 1, 64'h0};

        apply_reset();

        // Arbitration table in IDLE; valids dropped before the edge so nothing is captured.
        for (int i = 0; i < 4; i++) begin
            if_req_valid = av[i].if_v; ls_req_valid = av[i].ls_v;
            #1;
            chk("arb_if_ready", if_req_ready, av[i].exp_if_rdy);
            chk("arb_ls_ready", ls_req_ready, av[i].exp_ls_rdy);
            if_req_valid = 0; ls_req_valid = 0;
            cycle();
            chk("arb_no_capture_busy", busy, 0);
        end

        // Transaction table.
        for (int i = 0; i < 5; i++) run_txn(tv[i]);

        // Spurious response in IDLE.
        apply_reset();
        mem_rsp_valid = 1; mem_rsp_data = 64'hFEED_FACE_FEED_FACE;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("spur_if_rsp", if_rsp_valid, 0);
            chk("spur_ls_rsp", ls_rsp_valid, 0);
            chk("spur_busy", busy, 0);
        end
        mem_rsp_valid = 0;

        // Both requesters valid continuously with a zero-latency memory.
        apply_reset();
        if_req_valid = 1; if_req_addr = 64'h8000_0100;
        ls_req_valid = 1; ls_req_we = 0; ls_req_addr = 64'h8000_4000; ls_req_wmask = 8'h00;
        mem_req_ready = 1; mem_rsp_valid = 1; mem_rsp_data = 64'h1111_2222_3333_4444;
        for (int i = 0; i < 30; i++) begin
            cycle();
            chk("one_ready_only", s_if_ready & s_ls_ready, 0);
            if (s_if_ready || s_ls_ready) begin
                grant_if_q.push_back(s_if_ready);
                grant_cyc_q.push_back(i);
            end
        end
        if_req_valid = 0; ls_req_valid = 0;
        repeat (3) cycle();
        idle_inputs();
        chk("starve_grant_count", grant_if_q.size(), 10);
        for (int k = 0; k < grant_if_q.size() && k < 10; k++) begin
            chk("starve_grant_is_if", grant_if_q[k], (k % (SM + 1)) == SM);
            chk("starve_grant_cycle", grant_cyc_q[k], 3 * k);
        end

        // Reset during WAIT after building up the starvation count.
        apply_reset();
        if_req_valid = 1; if_req_addr = 64'h8000_0200;
        ls_req_valid = 1; ls_req_we = 0; ls_req_addr = 64'h8000_5000;
        mem_req_ready = 1; mem_rsp_valid = 1; mem_rsp_data = 64'h7777_8888_9999_AAAA;
        for (int i = 0; i < 10; i++) cycle();
        chk("rst_fourth_grant_ls", s_ls_ready, 1);
        ls_req_valid = 0; if_req_valid = 0; mem_rsp_valid = 0;
        cycle();
        mem_req_ready = 0;
        #1;
        chk("rst_in_wait_busy", busy, 1);
        sys_rst = 0;
        model_clear();
        #1;
        chk_all_zero("midrst");
        @(posedge sys_clk);
        #1;
        sys_rst = 1;
        mem_rsp_valid = 1; mem_rsp_data = 64'h5A5A_5A5A_5A5A_5A5A;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("midrst_no_ls_rsp", ls_rsp_valid, 0);
            chk("midrst_no_if_rsp", if_rsp_valid, 0);
        end
        mem_rsp_valid = 0;
        if_req_valid = 1; ls_req_valid = 1;
        #1;
        chk("midrst_starve_clear_ls", ls_req_ready, 1);
        chk("midrst_starve_clear_if", if_req_ready, 0);
        if_req_valid = 0; ls_req_valid = 0;
        cycle();

        // Random traffic against the reference model.
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            if_req_valid  = ($urandom_range(0, 1) == 1);
            if_req_addr   = {$urandom, $urandom};
            ls_req_valid  = ($urandom_range(0, 1) == 1);
            ls_req_we     = ($urandom_range(0, 1) == 1);
            ls_req_addr   = {$urandom, $urandom};
            ls_req_wdata  = {$urandom, $urandom};
            ls_req_wmask  = 8'($urandom);
            mem_req_ready = ($urandom_range(0, 1) == 1);
            mem_rsp_valid = ($urandom_range(0, 4) < 2);
            mem_rsp_data  = {$urandom, $urandom};
            cycle();
        end
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
